// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared scancodes, joystick bit map and sequencer states
package arcade_input_pkg;

    // Direction codes match on the low byte only; the extended flag is don't-care.
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;

    localparam logic [8:0] KC_SPACE = 9'h029;
    localparam logic [8:0] KC_CTRL  = 9'h014;
    localparam logic [8:0] KC_F1    = 9'h005;
    localparam logic [8:0] KC_F2    = 9'h006;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COIN,
        ST_GAP,
        ST_START
    } seq_state_e;

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// rtl/arcade_input_ctrl_if.sv - player-input bundle between hps_io side and the core
interface arcade_input_ctrl_if;

    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        orient_horz;
    logic        left_out;
    logic        right_out;
    logic        fire_out;
    logic        coin_out;
    logic        start1_out;
    logic        start2_out;
    logic        busy;

    modport master (
        output ps2_key, joy, orient_horz,
        input  left_out, right_out, fire_out, coin_out, start1_out, start2_out, busy
    );

    modport slave (
        input  ps2_key, joy, orient_horz,
        output left_out, right_out, fire_out, coin_out, start1_out, start2_out, busy
    );

endinterface

// File: rtl/arcade_input_ctrl_ps2_key_latch.sv
// rtl/arcade_input_ctrl_ps2_key_latch.sv - PS/2 event toggle detect and held-key registers
module ps2_key_latch
    import arcade_input_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic        key_up,
    output logic        key_down,
    output logic        key_left,
    output logic        key_right,
    output logic        key_fire,
    output logic        key_f1,
    output logic        key_f2
);

    logic toggle_q;
    logic up_q, down_q, left_q, right_q, fire_q, f1_q, f2_q;
    logic up_d, down_d, left_d, right_d, fire_d, f1_d, f2_d;
    logic key_event;
    logic pressed;

    assign key_event = ps2_key[10] ^ toggle_q;
    assign pressed   = ps2_key[9];

    always_comb begin
        up_d    = up_q;
        down_d  = down_q;
        left_d  = left_q;
        right_d = right_q;
        fire_d  = fire_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        if (key_event) begin
            if (ps2_key[7:0] == KC_UP)    up_d    = pressed;
            if (ps2_key[7:0] == KC_DOWN)  down_d  = pressed;
            if (ps2_key[7:0] == KC_LEFT)  left_d  = pressed;
            if (ps2_key[7:0] == KC_RIGHT) right_d = pressed;
            // Space and ctrl share one fire register: the last event of either wins.
            if (ps2_key[8:0] == KC_SPACE || ps2_key[8:0] == KC_CTRL) fire_d = pressed;
            if (ps2_key[8:0] == KC_F1)    f1_d    = pressed;
            if (ps2_key[8:0] == KC_F2)    f2_d    = pressed;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            fire_q   <= 1'b0;
            f1_q     <= 1'b0;
            f2_q     <= 1'b0;
        end else begin
            toggle_q <= ps2_key[10];
            up_q     <= up_d;
            down_q   <= down_d;
            left_q   <= left_d;
            right_q  <= right_d;
            fire_q   <= fire_d;
            f1_q     <= f1_d;
            f2_q     <= f2_d;
        end
    end

    assign key_up    = up_q;
    assign key_down  = down_q;
    assign key_left  = left_q;
    assign key_right = right_q;
    assign key_fire  = fire_q;
    assign key_f1    = f1_q;
    assign key_f2    = f2_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// rtl/arcade_input_ctrl.sv - key/joystick merge, orientation remap and coin-then-start sequencer
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE_CYCLES  = 1800000,
    parameter int HOLDOFF_CYCLES     = 3600000,
    parameter int START_PULSE_CYCLES = 1800000,
    parameter int CNT_W              = 22
)
(
    input  logic                clk_sys,
    input  logic                reset_n,
    arcade_input_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic key_up, key_down, key_left, key_right, key_fire, key_f1, key_f2;

    ps2_key_latch u_key_latch (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (bus.ps2_key),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_fire  (key_fire),
        .key_f1    (key_f1),
        .key_f2    (key_f2)
    );

    logic unused_joy;
    assign unused_joy = &{1'b0, bus.joy[15:7]};

    logic left_q, right_q, fire_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            if (bus.orient_horz) begin
                left_q  <= key_down | bus.joy[JOY_DOWN];
                right_q <= key_up   | bus.joy[JOY_UP];
            end else begin
                left_q  <= key_left  | bus.joy[JOY_LEFT];
                right_q <= key_right | bus.joy[JOY_RIGHT];
            end
            fire_q <= key_fire | bus.joy[JOY_FIRE];
        end
    end

    logic req1, req2, req_any, req_q, trigger;

    assign req1    = key_f1 | bus.joy[JOY_START1];
    assign req2    = key_f2 | bus.joy[JOY_START2];
    assign req_any = req1 | req2;
    // Edge history runs in every state so a request held across a sequence cannot retrigger.
    assign trigger = req_any & ~req_q;

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             sel1_q, sel2_q;
    logic             coin_q, start1_q, start2_q, busy_q;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            sel1_q   <= 1'b0;
            sel2_q   <= 1'b0;
            coin_q   <= 1'b0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            req_q <= req_any;
            unique case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        sel1_q  <= req1;
                        sel2_q  <= req2;
                        cnt_q   <= '0;
                        coin_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_COIN;
                    end
                end
                ST_COIN: begin
                    if (cnt_q == COIN_LAST) begin
                        cnt_q   <= '0;
                        coin_q  <= 1'b0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q    <= '0;
                        start1_q <= sel1_q;
                        start2_q <= sel2_q;
                        state_q  <= ST_START;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_q    <= '0;
                        start1_q <= 1'b0;
                        start2_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            endcase
        end
    end

    assign bus.left_out   = left_q;
    assign bus.right_out  = right_q;
    assign bus.fire_out   = fire_q;
    assign bus.coin_out   = coin_q;
    assign bus.start1_out = start1_q;
    assign bus.start2_out = start2_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb/tb_arcade_input_ctrl.sv - scoreboard bench with a timeline reference model
module tb_arcade_input_ctrl;

    localparam int C   = 4;
    localparam int H   = 3;
    localparam int S   = 5;
    localparam int SEQ = C + H + S;

    typedef struct packed {
        logic left, right, fire, coin, s1, s2, busy;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if bus ();

    arcade_input_ctrl #(
        .COIN_PULSE_CYCLES  (C),
        .HOLDOFF_CYCLES     (H),
        .START_PULSE_CYCLES (S),
        .CNT_W              (22)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic [10:0] cur_pk  = '0;
    logic [15:0] cur_joy = '0;
    logic        cur_or  = 1'b0;
    logic        cur_rn  = 1'b0;
    logic        prev_rn = 1'b0;
    logic        tb_tog  = 1'b0;

    // Model: held keys by name, last trigger edge index and its selects.
    logic   m_ku, m_kd, m_kl, m_kr, m_kf, m_kf1, m_kf2;
    logic   m_tog, m_req_prev, m_s1, m_s2;
    longint m_t;
    longint edge_n = 0;

    function automatic void chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (time %0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        {m_ku, m_kd, m_kl, m_kr, m_kf, m_kf1, m_kf2} = '0;
        m_tog = 1'b0;
        m_req_prev = 1'b0;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_t = -1000;
    endfunction

    task automatic step();
        exp_t   e;
        logic   r1, r2;
        longint d;
        @(negedge clk_sys);
        bus.ps2_key     = cur_pk;
        bus.joy         = cur_joy;
        bus.orient_horz = cur_or;
        reset_n         = cur_rn;
        edge_n++;
        if (!cur_rn) begin
            if (prev_rn) begin
                #1;
                chk("async_coin", bus.coin_out, 1'b0);
                chk("async_start1", bus.start1_out, 1'b0);
                chk("async_start2", bus.start2_out, 1'b0);
                chk("async_busy", bus.busy, 1'b0);
            end
            prev_rn = cur_rn;
            m_reset();
            exp_q.push_back('0);
            return;
        end
        prev_rn = cur_rn;
        e.left  = cur_or ? (m_kd | cur_joy[2]) : (m_kl | cur_joy[1]);
        e.right = cur_or ? (m_ku | cur_joy[3]) : (m_kr | cur_joy[0]);
        e.fire  = m_kf | cur_joy[4];
        r1 = m_kf1 | cur_joy[5];
        r2 = m_kf2 | cur_joy[6];
        if ((r1 | r2) && !m_req_prev && (edge_n - m_t >= SEQ)) begin
            m_t  = edge_n;
            m_s1 = r1;
            m_s2 = r2;
        end
        m_req_prev = r1 | r2;
        d = edge_n - m_t;
        e.coin = (d >= 0) && (d < C);
        e.busy = (d >= 0) && (d < SEQ);
        e.s1   = m_s1 && (d >= C + H) && (d < SEQ);
        e.s2   = m_s2 && (d >= C + H) && (d < SEQ);
        if (cur_pk[10] != m_tog) begin
            if (cur_pk[7:0] == 8'h75) m_ku = cur_pk[9];
            if (cur_pk[7:0] == 8'h72) m_kd = cur_pk[9];
            if (cur_pk[7:0] == 8'h6B) m_kl = cur_pk[9];
            if (cur_pk[7:0] == 8'h74) m_kr = cur_pk[9];
            if (cur_pk[8:0] == 9'h029 || cur_pk[8:0] == 9'h014) m_kf = cur_pk[9];
            if (cur_pk[8:0] == 9'h005) m_kf1 = cur_pk[9];
            if (cur_pk[8:0] == 9'h006) m_kf2 = cur_pk[9];
        end
        m_tog = cur_pk[10];
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic key(input logic [8:0] code, input logic pressed);
        tb_tog = ~tb_tog;
        cur_pk = {tb_tog, pressed, code};
        step();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("left_out", bus.left_out, e.left);
                chk("right_out", bus.right_out, e.right);
                chk("fire_out", bus.fire_out, e.fire);
                chk("coin_out", bus.coin_out, e.coin);
                chk("start1_out", bus.start1_out, e.s1);
                chk("start2_out", bus.start2_out, e.s2);
                chk("busy", bus.busy, e.busy);
            end
        end
    end

    initial begin
        int r;
        bus.ps2_key = '0;
        bus.joy = '0;
        bus.orient_horz = 1'b0;
        m_reset();

        tick(3);
        cur_rn = 1'b1;
        tick(2);

        key(9'h06B, 1'b1); tick(3);
        key(9'h06B, 1'b0); tick(3);
        cur_or = 1'b1;
        key(9'h06B, 1'b1); tick(3);
        key(9'h06B, 1'b0); tick(2);
        cur_or = 1'b0;

        cur_joy[6] = 1'b1; tick(16);
        cur_joy[6] = 1'b0; tick(2);

        cur_joy[5] = 1'b1; cur_joy[6] = 1'b1; tick(15);
        cur_joy = '0; tick(2);

        key(9'h005, 1'b1); tick(6);
        key(9'h005, 1'b1); tick(25);
        key(9'h005, 1'b0); tick(2);
        key(9'h005, 1'b1); tick(15);
        key(9'h005, 1'b0); tick(2);

        cur_joy[6] = 1'b1; tick(3);
        cur_rn = 1'b0; tick(2);
        cur_rn = 1'b1; cur_joy[6] = 1'b0; tick(2);
        cur_joy[6] = 1'b1; tick(15);
        cur_joy[6] = 1'b0; tick(1);

        key(9'h129, 1'b1); tick(3);
        cur_or = 1'b1;
        key(9'h175, 1'b1); tick(3);
        key(9'h175, 1'b0); tick(3);
        cur_or = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                r = $urandom_range(11);
                case (r)
                    0: tb_tog = tb_tog;
                    default: ;
                endcase
                tb_tog = ~tb_tog;
                case (r)
                    0: cur_pk[8:0] = 9'h075;
                    1: cur_pk[8:0] = 9'h172;
                    2: cur_pk[8:0] = 9'h06B;
                    3: cur_pk[8:0] = 9'h174;
                    4: cur_pk[8:0] = 9'h029;
                    5: cur_pk[8:0] = 9'h014;
                    6: cur_pk[8:0] = 9'h005;
                    7: cur_pk[8:0] = 9'h006;
                    8: cur_pk[8:0] = 9'h105;
                    9: cur_pk[8:0] = 9'h129;
                    10: cur_pk[8:0] = 9'h033;
                    default: cur_pk[8:0] = 9'h114;
                endcase
                cur_pk[9]  = 1'($urandom_range(1));
                cur_pk[10] = tb_tog;
            end
            if ($urandom_range(9) == 0) cur_joy[$urandom_range(6)] ^= 1'b1;
            if ($urandom_range(99) == 0) cur_joy[7 + $urandom_range(8)] ^= 1'b1;
            if ($urandom_range(49) == 0) cur_or = ~cur_or;
            cur_rn = ($urandom_range(599) != 0) || !cur_rn ? 1'b1 : 1'b0;
            if ($urandom_range(599) == 0) cur_rn = 1'b0;
            step();
        end
        cur_rn = 1'b1;
        tick(SEQ + 2);

        @(posedge clk_sys);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
